// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // A new operation may only be accepted while not shifting.
    function automatic logic can_accept(input state_t st);
        return (st != S_SHIFT);
    endfunction

endpackage

// File: rtl/full_adder_explicit.sv
// One-bit full adder written out as explicit propagate/generate terms.
module full_adder_explicit (
    input  logic ci,
    input  logic a,
    input  logic b,
    output logic co,
    output logic s
);

    logic p;
    logic g;

    // NOTE: continuous assigns are purely combinational, so no latch can be inferred here.
    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign co = g | (p & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds one full-adder slice LSB first, WIDTH cycles per add.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output 'ovf'.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic             fa_co;
    logic             fa_s;
    logic [WIDTH-1:0] res_next;

    full_adder_explicit u_slice (
        .ci (carry),
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .co (fa_co),
        .s  (fa_s)
    );

    // Sum bits arrive LSB first, so they enter at the top and walk down.
    assign res_next = {fa_s, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
            done <= 1'b0;
            case (state)
                S_SHIFT: begin
                    carry <= fa_co;
                    res   <= res_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // 'carry' still holds the carry into the MSB on this edge.
                        ovf   <= carry ^ fa_co;
`endif
                    end
                end
                default: begin
                    // IDLE, DONE and the unused encoding all behave as IDLE.
                    if (start && can_accept(state)) begin
                        state <= S_SHIFT;
                        busy  <= 1'b1;
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= cin;
                        res   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Pulse start for one cycle, scramble inputs during SHIFT, wait (bounded) for done.
    // lat counts negedges after the start edge; busy_cyc counts negedges with busy high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int lat, output int busy_cyc);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = ~a; b_in = ~b; cin = ~c;
        lat = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, gap, pulses;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf",  32'(ovf),  32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of single operations
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, lat, bc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
            check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
            check($sformatf("v%0d_sum_hold", i), 32'(sum), 32'(vecs[i].sum));
        end

        // start while busy is ignored; sum port keeps the previous result meanwhile
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (2) begin @(negedge clk); lat++; end
        a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
        check("busy_mid_shift", 32'(busy), 32'd1);
        check("sum_hidden_mid_shift", 32'(sum), 32'h00);
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("ign_latency", 32'(lat), 32'd9);
        check("ign_sum", 32'(sum), 32'h30);
        check("ign_cout", 32'(cout), 32'd0);
        pulses = 0;
        repeat (12) begin @(negedge clk); if (done) pulses++; end
        check("ign_no_second_done", 32'(pulses), 32'd0);
        check("ign_idle_busy", 32'(busy), 32'd0);

        // start held high: back-to-back accepts in each DONE cycle
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a_in = 8'h80; b_in = 8'h80;
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("b2b_first_latency", 32'(lat), 32'd9);
        check("b2b_first_sum", 32'(sum), 32'h02);
        check("b2b_first_cout", 32'(cout), 32'd0);
        wait_done(gap);
        start = 1'b0;
        check("b2b_gap", 32'(gap), 32'd9);
        check("b2b_second_sum", 32'(sum), 32'h00);
        check("b2b_second_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check("b2b_second_ovf", 32'(ovf), 32'd1);
`endif
        @(negedge clk);
        check("b2b_stop_busy", 32'(busy), 32'd0);
        check("b2b_stop_done", 32'(done), 32'd0);

        // Reset in the middle of SHIFT
        do_op(8'h12, 8'h34, 1'b0, lat, bc);
        check("pre_rst_sum", 32'(sum), 32'h46);
        @(negedge clk);
        a_in = 8'h0F; b_in = 8'h01; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum",  32'(sum),  32'd0);
        check("arst_cout", 32'(cout), 32'd1 - 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin @(negedge clk); if (done || busy) pulses++; end
        check("arst_no_done", 32'(pulses), 32'd0);
        do_op(8'h21, 8'h12, 1'b0, lat, bc);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_sum", 32'(sum), 32'h33);
        check("post_rst_cout", 32'(cout), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder. Adds two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder bit-slice.
- A registered carry is fed back into the slice on each bit, and each sum bit is shifted into a result register.
- Sits around the full-adder cell as its sequencing stage. It supplies ci/a/b each cycle and consumes co/s.
- Trades area for latency against a ripple-carry array.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE.
- a_in  input  WIDTH  operand A; captured on accepted start.
- b_in  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  final carry-out; same hold rule as sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, busy = 0, done = 0, sum = 0, cout = 0.
  - Operand shift registers, carry flop and bit counter all cleared.
  - Release is synchronous to the next clk edge.
- State IDLE:
  - busy = 0, done = 0.
  - start = 1 at edge E0 loads a_in, b_in into shift regs A and B, cin into the carry flop, counter = 0, and clears the result reg. Next state SHIFT.
- State SHIFT:
  - Each edge: slice inputs are a = A[0], b = B[0], ci = carry.
  - Carry flop <= co. Result reg shifts right with s entering the MSB. A and B shift right. Counter += 1.
  - When counter reaches WIDTH-1 at an edge, that edge processes the last bit and the next state is DONE.
  - Edges E1..EWIDTH process bits 0..WIDTH-1.
- State DONE:
  - done = 1 for exactly one cycle, the cycle following EWIDTH. busy = 0.
  - sum = result reg, cout = carry flop.
  - Next state is IDLE, or SHIFT if start = 1 (back-to-back accept; same load actions as IDLE).
- Latency: done high WIDTH+1 cycles after the start edge. Throughput: one add per WIDTH+1 cycles.
- Boundary conditions:
  - start while busy: ignored. No reload, no queuing, operands unchanged.
  - start held high continuously: a new op is accepted in every DONE cycle.
  - a_in/b_in/cin changing during SHIFT: no effect.
  - Arithmetic: sum = (a_in + b_in + cin) mod 2^WIDTH, cout = bit WIDTH of the full sum. Unsigned; no saturation.
  - Reset mid-SHIFT: operation abandoned, no done pulse, outputs return to reset values immediately.
  - sum and cout update only on entry to DONE. Intermediate partial sums are never visible on the sum port.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), reset 0, same timing and hold rule as sum.
  - ovf = signed two's-complement overflow = (carry into MSB) XOR cout. The carry into the MSB is captured when processing bit WIDTH-1.
- Undefined: port absent; no extra flops; all other behaviour identical.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding localparams ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2 (2'd3 unused, decodes to IDLE);
  - default WIDTH constant.
- One sub-module: the bit-slice is an instance of the team's existing full_adder_explicit cell (ports ci, a, b, co, s). The controller contains no adder logic of its own.

Test Plan:
- WIDTH=8, a_in=0x5A, b_in=0x3C, cin=0, start pulse -> done exactly 9 cycles after the start edge, sum=0x96, cout=0, busy high for 8 cycles.
- a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x10+0x20; assert start again with 0xAA/0x55 at cycle 3 of SHIFT -> ignored. Result sum=0x30, cout=0, single done pulse.
- start held high with two operand sets (0x01+0x01, then 0x80+0x80) -> done pulses 9 cycles apart. Results sum=0x02/cout=0, then sum=0x00/cout=1.
- Drive rst_n low at cycle 4 of SHIFT -> busy, done, sum, cout go 0 asynchronously (before the next edge). No done pulse. The next start completes normally.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, ovf=1. 0x80+0x80 -> sum=0x00, cout=1, ovf=1. 0x05+0x03 -> ovf=0.
